// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch next-PC sequencer.
//  - state_e : sequencer states (BOOT, RUN, FLUSH)
//  - XLEN    : PC width
//  - PC_STEP : sequential fetch increment
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle of correction / predictor / fetch handshake signals around the
// next-PC sequencer.
//  master : drives corr_*, pred_*, fetch_ready; observes pc_*, flush,
//           pred_disable, mis_cnt
//  slave  : the sequencer itself (opposite directions)
interface fetch_redirect_if #(
  parameter int CNT_W = 3
);
  import fetch_pkg::*;

  logic            corr_valid;
  logic [XLEN-1:0] corr_pc;
  logic            pred_hit;
  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic            fetch_ready;
  logic            pc_valid;
  logic [XLEN-1:0] pc_out;
  logic            flush;
  logic            pred_disable;
  logic [CNT_W-1:0] mis_cnt;

  modport master (
    output corr_valid, corr_pc, pred_hit, pred_valid, pred_pc, fetch_ready,
    input  pc_valid, pc_out, flush, pred_disable, mis_cnt
  );

  modport slave (
    input  corr_valid, corr_pc, pred_hit, pred_valid, pred_pc, fetch_ready,
    output pc_valid, pc_out, flush, pred_disable, mis_cnt
  );
endinterface

// File: rtl/fetch_redirect_ctrl_mispredict_counter.sv
// Consecutive-mispredict counter with predictor throttle.
//  fire/rst   : clock, synchronous active-high reset
//  i_corr     : mispredict reported this cycle (count up, saturating)
//  i_hit      : correct prediction reported (clears count unless i_corr)
//  o_cnt      : registered count
//  o_disable  : registered (next count >= THRESH)
module mispredict_counter #(
  parameter int CNT_W  = 3,
  parameter int THRESH = 4
) (
  input  logic             fire,
  input  logic             rst,
  input  logic             i_corr,
  input  logic             i_hit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_disable
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_disable;
  logic [CNT_W-1:0] w_cnt_next;

  // Next count: a mispredict wins over a hit in the same cycle.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_corr) begin
      if (r_cnt != CNT_MAX) begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end else begin
        w_cnt_next = r_cnt;
      end
    end else if (i_hit) begin
      w_cnt_next = '0;
    end else begin
      w_cnt_next = r_cnt;
    end
  end

  // Count and throttle registers; throttle is derived from the next count.
  always_ff @(posedge fire) begin
    if (rst) begin
      r_cnt     <= '0;
      r_disable <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_disable <= (w_cnt_next >= THR);
    end
  end

  assign o_cnt     = r_cnt;
  assign o_disable = r_disable;
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencer for instruction fetch. Chooses between execute
// corrections, predictor redirects and sequential PC+4, runs a flush window
// after every correction and throttles the predictor on repeated mispredicts.
//  fire, rst  : clock, synchronous active-high reset
//  bus        : fetch_redirect_if.slave (correction, predictor, fetch side)
//  redir_total, redir_pred : only when REDIRECT_STATS_EN is defined; counts of
//               accepted corrections and accepted predictor redirects
module fetch_redirect_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 3,
  parameter int              THRESH       = 4
) (
  input  logic             fire,
  input  logic             rst,
  fetch_redirect_if.slave  bus
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0]      redir_total,
  output logic [31:0]      redir_pred
`endif
);
  localparam int TMR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FLUSH_CYCLES - 1);

  state_e           r_state;
  logic [XLEN-1:0]  r_pc_out;
  logic             r_pc_valid;
  logic             r_flush;
  logic [TMR_W-1:0] r_timer;

  logic             w_handshake;
  logic             w_pred_take;
  logic [XLEN-1:0]  w_seq_pc;
  logic [CNT_W-1:0] w_mis_cnt;
  logic             w_pred_disable;

  assign w_handshake = r_pc_valid & bus.fetch_ready;
  assign w_pred_take = bus.pred_valid & ~w_pred_disable;
  assign w_seq_pc    = r_pc_out + PC_STEP;

  mispredict_counter #(
    .CNT_W  (CNT_W),
    .THRESH (THRESH)
  ) u_mis_cnt (
    .fire      (fire),
    .rst       (rst),
    .i_corr    (bus.corr_valid),
    .i_hit     (bus.pred_hit),
    .o_cnt     (w_mis_cnt),
    .o_disable (w_pred_disable)
  );

  // Sequencer FSM; pc_out only moves on a handshake or a correction.
  always_ff @(posedge fire) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc_out   <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_timer    <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        RUN: begin
          if (bus.corr_valid) begin
            r_state    <= FLUSH;
            r_pc_out   <= bus.corr_pc;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b1;
            r_timer    <= TMR_LOAD;
          end else if (w_handshake) begin
            r_pc_out <= w_pred_take ? bus.pred_pc : w_seq_pc;
          end
        end
        FLUSH: begin
          // A fresh correction restarts the window with the new target.
          if (bus.corr_valid) begin
            r_pc_out <= bus.corr_pc;
            r_timer  <= TMR_LOAD;
          end else if (r_timer == '0) begin
            r_state    <= RUN;
            r_pc_valid <= 1'b1;
            r_flush    <= 1'b0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: begin
          r_state    <= BOOT;
          r_pc_valid <= 1'b0;
          r_flush    <= 1'b0;
        end
      endcase
    end
  end

`ifdef REDIRECT_STATS_EN
  logic [31:0] r_redir_total;
  logic [31:0] r_redir_pred;

  // Redirect statistics; corrections in BOOT are not accepted.
  always_ff @(posedge fire) begin
    if (rst) begin
      r_redir_total <= 32'd0;
      r_redir_pred  <= 32'd0;
    end else begin
      if (bus.corr_valid && (r_state != BOOT)) begin
        r_redir_total <= r_redir_total + 32'd1;
      end
      if ((r_state == RUN) && !bus.corr_valid && w_handshake && w_pred_take) begin
        r_redir_pred <= r_redir_pred + 32'd1;
      end
    end
  end

  assign redir_total = r_redir_total;
  assign redir_pred  = r_redir_pred;
`endif

  assign bus.pc_valid     = r_pc_valid;
  assign bus.pc_out       = r_pc_out;
  assign bus.flush        = r_flush;
  assign bus.pred_disable = w_pred_disable;
  assign bus.mis_cnt      = w_mis_cnt;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_fetch_redirect_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W = 3;
  localparam int THRESH = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic fire = 1'b0;
  logic rst  = 1'b1;
  always #5 fire = ~fire;

  fetch_redirect_if #(.CNT_W(CNT_W)) bus ();

`ifdef REDIRECT_STATS_EN
  logic [31:0] redir_total;
  logic [31:0] redir_pred;
`endif

  fetch_redirect_ctrl #(
    .RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W), .THRESH(THRESH)
  ) dut (
    .fire(fire),
    .rst(rst),
    .bus(bus)
`ifdef REDIRECT_STATS_EN
    , .redir_total(redir_total)
    , .redir_pred(redir_pred)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: remaining flush cycles instead of a state machine.
  bit          m_boot;
  logic [31:0] m_pc;
  int          m_left;
  int          m_cnt;
  logic [31:0] m_total;
  logic [31:0] m_predc;

  function automatic logic [39:0] m_expect();
    logic v, f, d;
    v = !m_boot && (m_left == 0);
    f = (m_left > 0);
    d = (m_cnt >= THRESH);
    return {v, m_pc, f, d, 3'(m_cnt)};
  endfunction

  task automatic set_idle();
    bus.corr_valid = 1'b0; bus.corr_pc = 32'd0;
    bus.pred_hit = 1'b0; bus.pred_valid = 1'b0; bus.pred_pc = 32'd0;
    bus.fetch_ready = 1'b1;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge.
  task automatic tick();
    bit dis;
    @(posedge fire);
    dis = (m_cnt >= THRESH);
    if (rst) begin
      m_boot = 1'b1; m_pc = RESET_PC; m_left = 0; m_cnt = 0;
      m_total = 32'd0; m_predc = 32'd0;
    end else begin
      if (bus.corr_valid) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      else if (bus.pred_hit) m_cnt = 0;
      if (m_boot) m_boot = 1'b0;
      else if (bus.corr_valid) begin
        m_pc = bus.corr_pc; m_left = FLUSH_CYCLES; m_total = m_total + 32'd1;
      end else if (m_left > 0) m_left = m_left - 1;
      else if (bus.fetch_ready) begin
        if (bus.pred_valid && !dis) begin
          m_pc = bus.pred_pc; m_predc = m_predc + 32'd1;
        end else m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle();
    tick(); tick();
    n_cmp++;
    if ({bus.pc_valid, bus.pc_out, bus.flush, bus.pred_disable, bus.mis_cnt} !== {1'b0, RESET_PC, 1'b0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL reset_state: got %h required %h",
        {bus.pc_valid, bus.pc_out, bus.flush, bus.pred_disable, bus.mis_cnt}, {1'b0, RESET_PC, 1'b0, 1'b0, 3'd0});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.pc_valid !== 1'b1 || bus.pc_out !== 32'h0) begin
      n_fail++; $display("FAIL boot_to_run: got valid=%b pc=%h required valid=1 pc=00000000", bus.pc_valid, bus.pc_out);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [2] = '{32'h4, 32'h8};
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus.pc_out !== exp_pc[i] || bus.flush !== 1'b0 || bus.pc_valid !== 1'b1) begin
        n_fail++; $display("FAIL sequential[%0d]: got pc=%h flush=%b required pc=%h flush=0", i, bus.pc_out, bus.flush, exp_pc[i]);
      end
    end
  endtask

  task automatic test_predict();
    bus.pred_valid = 1'b1; bus.pred_pc = 32'h100;
    tick();
    n_cmp++;
    if (bus.pc_out !== 32'h100) begin
      n_fail++; $display("FAIL predict_redirect: got pc=%h required pc=00000100", bus.pc_out);
    end
    bus.pred_pc = 32'h180; bus.fetch_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if (bus.pc_out !== 32'h100 || bus.pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL no_handshake_hold: got pc=%h required pc=00000100", bus.pc_out);
    end
    set_idle();
  endtask

  task automatic test_correction();
    bus.corr_valid = 1'b1; bus.corr_pc = 32'h200; bus.fetch_ready = 1'b0;
    tick();
    set_idle();
    for (int i = 0; i < FLUSH_CYCLES; i++) begin
      n_cmp++;
      if (bus.flush !== 1'b1 || bus.pc_valid !== 1'b0) begin
        n_fail++; $display("FAIL corr_flush[%0d]: got flush=%b valid=%b required flush=1 valid=0", i, bus.flush, bus.pc_valid);
      end
      tick();
    end
    n_cmp++;
    if (bus.flush !== 1'b0 || bus.pc_valid !== 1'b1 || bus.pc_out !== 32'h200) begin
      n_fail++; $display("FAIL corr_target: got flush=%b valid=%b pc=%h required 0/1/00000200", bus.flush, bus.pc_valid, bus.pc_out);
    end
  endtask

  task automatic test_priority();
    bus.corr_valid = 1'b1; bus.corr_pc = 32'h300; bus.pred_valid = 1'b1; bus.pred_pc = 32'h400;
    tick();
    set_idle();
    n_cmp++;
    if (bus.pc_out !== 32'h300 || bus.flush !== 1'b1) begin
      n_fail++; $display("FAIL corr_beats_pred: got pc=%h flush=%b required pc=00000300 flush=1", bus.pc_out, bus.flush);
    end
    bus.corr_valid = 1'b1; bus.corr_pc = 32'h500;
    tick();
    set_idle();
    tick();
    n_cmp++;
    if (bus.flush !== 1'b1 || bus.pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_extend: got flush=%b valid=%b required flush=1 valid=0", bus.flush, bus.pc_valid);
    end
    tick();
    n_cmp++;
    if (bus.pc_valid !== 1'b1 || bus.pc_out !== 32'h500 || bus.mis_cnt !== 3'd3) begin
      n_fail++; $display("FAIL flush_end_target: got valid=%b pc=%h cnt=%0d required 1/00000500/3", bus.pc_valid, bus.pc_out, bus.mis_cnt);
    end
  endtask

  task automatic test_throttle();
    bus.pred_hit = 1'b1;
    tick();
    set_idle();
    for (int i = 0; i < 4; i++) begin
      bus.corr_valid = 1'b1; bus.corr_pc = 32'h600 + 32'(4 * i);
      tick();
      set_idle();
      tick(); tick();
    end
    n_cmp++;
    if (bus.mis_cnt !== 3'd4 || bus.pred_disable !== 1'b1) begin
      n_fail++; $display("FAIL throttle_on: got cnt=%0d dis=%b required cnt=4 dis=1", bus.mis_cnt, bus.pred_disable);
    end
    bus.pred_valid = 1'b1; bus.pred_pc = 32'h700;
    tick();
    n_cmp++;
    if (bus.pc_out !== 32'h610) begin
      n_fail++; $display("FAIL pred_ignored: got pc=%h required pc=00000610", bus.pc_out);
    end
    set_idle();
    bus.corr_valid = 1'b1; bus.corr_pc = 32'h900;
    for (int i = 0; i < 5; i++) tick();
    set_idle();
    n_cmp++;
    if (bus.mis_cnt !== 3'd7) begin
      n_fail++; $display("FAIL cnt_saturate: got cnt=%0d required cnt=7", bus.mis_cnt);
    end
    tick(); tick();
    bus.pred_hit = 1'b1;
    tick();
    set_idle();
    n_cmp++;
    if (bus.mis_cnt !== 3'd0) begin
      n_fail++; $display("FAIL hit_clears_cnt: got cnt=%0d required cnt=0", bus.mis_cnt);
    end
    tick();
    n_cmp++;
    if (bus.pred_disable !== 1'b0) begin
      n_fail++; $display("FAIL throttle_off: got dis=%b required dis=0", bus.pred_disable);
    end
  endtask

  task automatic test_wrap();
    bus.corr_valid = 1'b1; bus.corr_pc = 32'hFFFF_FFFC;
    tick();
    set_idle();
    tick(); tick();
    tick();
    n_cmp++;
    if (bus.pc_out !== 32'h0 || bus.pc_valid !== 1'b1) begin
      n_fail++; $display("FAIL pc_wrap: got pc=%h valid=%b required pc=00000000 valid=1", bus.pc_out, bus.pc_valid);
    end
  endtask

  task automatic test_reset_mid_flush();
    bus.corr_valid = 1'b1; bus.corr_pc = 32'h800;
    tick();
    set_idle();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.pc_valid, bus.pc_out, bus.flush, bus.pred_disable, bus.mis_cnt} !== {1'b0, RESET_PC, 1'b0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL reset_mid_flush: got %h required %h",
        {bus.pc_valid, bus.pc_out, bus.flush, bus.pred_disable, bus.mis_cnt}, {1'b0, RESET_PC, 1'b0, 1'b0, 3'd0});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      bus.corr_valid  = ($urandom_range(0, 7) == 0);
      bus.corr_pc     = $urandom() & 32'hFFFF_FFFC;
      bus.pred_hit    = ($urandom_range(0, 3) == 0);
      bus.pred_valid  = $urandom_range(0, 1) == 1;
      bus.pred_pc     = $urandom() & 32'hFFFF_FFFC;
      bus.fetch_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if ({bus.pc_valid, bus.pc_out, bus.flush, bus.pred_disable, bus.mis_cnt} !== m_expect()) begin
        n_fail++; $display("FAIL random[%0d]: got %h required %h", i,
          {bus.pc_valid, bus.pc_out, bus.flush, bus.pred_disable, bus.mis_cnt}, m_expect());
      end
`ifdef REDIRECT_STATS_EN
      n_cmp++;
      if (redir_total !== m_total || redir_pred !== m_predc) begin
        n_fail++; $display("FAIL stats[%0d]: got %0d/%0d required %0d/%0d", i, redir_total, redir_pred, m_total, m_predc);
      end
`endif
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_sequential();
    test_predict();
    test_correction();
    test_priority();
    test_throttle();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
